// File: rtl/gc_pkg.sv
// Package for the GameCube host-side poll transmitter and the response decoder.
// Contents:
//   GC_CMD_BITS  - length of the poll command in bits
//   GC_POLL_CMD  - poll command with the rumble bit (bit 0) cleared
//   gc_state_e   - transmitter state encoding
//   gc_lo_units  - low-phase length of one data bit, in microseconds
package gc_pkg;

    localparam int GC_CMD_BITS = 24;
    localparam logic [GC_CMD_BITS-1:0] GC_POLL_CMD = 24'h400300;

    typedef enum logic [2:0] {
        GC_IDLE,
        GC_BIT_LO,
        GC_BIT_HI,
        GC_STOP_LO,
        GC_RX_WIN
    } gc_state_e;

    // A bit cell is 4 us long. A '1' is short-low/long-high and a '0' is
    // long-low/short-high, so the high part is 4 minus this value.
    function automatic int gc_lo_units(input logic b);
        return b ? 1 : 3;
    endfunction

endpackage

// File: rtl/gc_poll_tx_if.sv
// Handshake bundle between the N64-side poll scheduler (master) and the
// GameCube poll transmitter (slave).
//   start      scheduler -> tx   single-cycle poll request
//   rumble     scheduler -> tx   rumble bit for the requested poll
//   gc_oe      tx -> pad/sched   1 = pull the data line low
//   rx_enable  tx -> decoder     high during the controller response window
//   busy       tx -> scheduler   frame in progress
//   done       tx -> scheduler   one-cycle end-of-frame pulse
interface gc_poll_tx_if;
    logic start;
    logic rumble;
    logic gc_oe;
    logic rx_enable;
    logic busy;
    logic done;

    modport master (
        output start,
        output rumble,
        input  gc_oe,
        input  rx_enable,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rumble,
        output gc_oe,
        output rx_enable,
        output busy,
        output done
    );
endinterface

// File: rtl/gc_phase_timer.sv
// Loadable down-counter shared by every timed phase of the poll frame
// (bit low/high phases, stop bit and the response window).
// Loading N makes the phase last N+1 cycles; tc is high while the count is 0.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   load      load load_val this cycle (takes priority over counting)
//   load_val  phase length minus one
//   tc        terminal count, high while the counter is at zero
module gc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign tc = (cnt_reg == '0);

endmodule

// File: rtl/gc_poll_tx.sv
// GameCube host-side poll transmitter.
// Sends the 24-bit poll command 0x4003_0R (R = rumble) MSB first plus a stop
// bit on the open-drain data line, then opens the response window by raising
// rx_enable for RX_WINDOW_US microseconds.
// Optional feature macro: GC_AUTO_POLL_EN - when defined, a free-running
// period counter issues an internal start every POLL_PERIOD_US microseconds.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (releases the line immediately)
//   bus    gc_poll_tx_if.slave: start/rumble in, gc_oe/rx_enable/busy/done out
module gc_poll_tx
    import gc_pkg::*;
#(
    parameter int CYC_PER_US     = 25,
    parameter int RX_WINDOW_US   = 400,
    parameter int POLL_PERIOD_US = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    gc_poll_tx_if.slave  bus
);

    localparam int RX_CYC = RX_WINDOW_US * CYC_PER_US;
    localparam int TW     = $clog2(RX_CYC + 1);

    if (CYC_PER_US < 1 || RX_WINDOW_US < 1 || POLL_PERIOD_US < 1) begin : g_param_check
        $error("gc_poll_tx: timing parameters must be positive");
    end

    gc_state_e              state_reg, state_next;
    logic [GC_CMD_BITS-1:0] cmd_reg, cmd_next;
    logic [4:0]             bit_idx_reg, bit_idx_next;
    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic                   tmr_tc;
    logic                   start_req;

    logic gc_oe_reg, gc_oe_next;
    logic rx_enable_reg, rx_enable_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    function automatic logic [TW-1:0] lo_len(input logic b);
        return TW'(gc_lo_units(b) * CYC_PER_US - 1);
    endfunction

    function automatic logic [TW-1:0] hi_len(input logic b);
        return TW'((4 - gc_lo_units(b)) * CYC_PER_US - 1);
    endfunction

`ifdef GC_AUTO_POLL_EN
    localparam int PER_CYC = POLL_PERIOD_US * CYC_PER_US;
    localparam int PW      = $clog2(PER_CYC);

    logic [PW-1:0] period_cnt_reg;
    logic          period_tick;

    assign period_tick = (period_cnt_reg == PW'(PER_CYC - 1));

    // Free-running: a tick that lands while busy is simply lost because the
    // FSM only looks at start_req in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg <= '0;
        end else if (period_tick) begin
            period_cnt_reg <= '0;
        end else begin
            period_cnt_reg <= period_cnt_reg + 1'b1;
        end
    end

    assign start_req = bus.start | period_tick;
`else
    assign start_req = bus.start;
`endif

    gc_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State register plus the frame datapath it steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= GC_IDLE;
            cmd_reg     <= '0;
            bit_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    // Next-state logic. Every phase change reloads the timer in the same
    // cycle as its terminal count, so phases abut with no dead cycle.
    always_comb begin
        state_next   = state_reg;
        cmd_next     = cmd_reg;
        bit_idx_next = bit_idx_reg;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        case (state_reg)
            GC_IDLE: begin
                if (start_req) begin
                    cmd_next     = GC_POLL_CMD | {{(GC_CMD_BITS-1){1'b0}}, bus.rumble};
                    bit_idx_next = 5'(GC_CMD_BITS - 1);
                    state_next   = GC_BIT_LO;
                    tmr_load     = 1'b1;
                    tmr_val      = lo_len(cmd_next[GC_CMD_BITS-1]);
                end
            end
            GC_BIT_LO: begin
                if (tmr_tc) begin
                    state_next = GC_BIT_HI;
                    tmr_load   = 1'b1;
                    tmr_val    = hi_len(cmd_reg[bit_idx_reg]);
                end
            end
            GC_BIT_HI: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (bit_idx_reg == 5'd0) begin
                        state_next = GC_STOP_LO;
                        tmr_val    = TW'(CYC_PER_US - 1);
                    end else begin
                        bit_idx_next = bit_idx_reg - 5'd1;
                        state_next   = GC_BIT_LO;
                        tmr_val      = lo_len(cmd_reg[bit_idx_next]);
                    end
                end
            end
            GC_STOP_LO: begin
                if (tmr_tc) begin
                    state_next = GC_RX_WIN;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(RX_CYC - 1);
                end
            end
            GC_RX_WIN: begin
                if (tmr_tc) begin
                    state_next = GC_IDLE;
                end
            end
            default: begin
                state_next = GC_IDLE;
            end
        endcase
    end

    // Output logic, decoded from the upcoming state so the registered
    // outputs line up with state_reg; gc_oe and rx_enable come from disjoint
    // states and therefore can never overlap.
    always_comb begin
        gc_oe_next     = (state_next == GC_BIT_LO) || (state_next == GC_STOP_LO);
        rx_enable_next = (state_next == GC_RX_WIN);
        busy_next      = (state_next != GC_IDLE);
        done_next      = (state_reg == GC_RX_WIN) && (state_next == GC_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gc_oe_reg     <= 1'b0;
            rx_enable_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            gc_oe_reg     <= gc_oe_next;
            rx_enable_reg <= rx_enable_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign bus.gc_oe     = gc_oe_reg;
    assign bus.rx_enable = rx_enable_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule
